// File: rtl/reg_x_if.sv
// reg_x_if: groups the write-side (wren, D) and read-side (Q) signals of a
// reg_x storage register so the register and its user share one bundle.
`timescale 1ns/1ps

interface reg_x_if #(
    parameter int WIDTH = 64
);
    logic             wren;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;

    // The user of the register drives data/enable and reads the contents.
    modport master (
        output wren,
        output D,
        input  Q
    );

    // The register itself consumes data/enable and presents its contents.
    modport slave (
        input  wren,
        input  D,
        output Q
    );
endinterface

// File: rtl/reg_x.sv
// reg_x: parameterised edge-triggered storage register with a single write
// enable, built as WIDTH bit-slices of (2:1 hold/load mux -> D flip-flop).
// Asynchronous active-high reset loads RESET_VALUE and dominates writes.
// Optional macro REG_X_GATE_DELAY_EN gives every mux a 50 ps propagation
// delay and every flop a 50 ps clock-to-Q delay; without it all primitives
// are zero-delay and behaviour is otherwise identical.
// The WIDTH of the connected reg_x_if must equal the WIDTH parameter here.
`timescale 1ns/1ps

module reg_x #(
    parameter int               WIDTH       = 64,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic    clk,
    input  logic    reset,
    reg_x_if.slave  bus
);

    // Per-slice flop outputs, gathered into one vector for the Q port.
    logic [WIDTH-1:0] q_vec;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_slice
            logic mux_out;
            logic q_ff;

`ifdef REG_X_GATE_DELAY_EN
            // Hold/load mux: wren selects new data, otherwise recirculate Q.
            assign #50ps mux_out = bus.wren ? bus.D[i] : q_ff;

            // Bit flop: reset is immediate, clocked loads appear 50 ps after the edge.
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    q_ff <= RESET_VALUE[i];
                else
                    q_ff <= #50ps mux_out;
            end
`else
            // Hold/load mux: wren selects new data, otherwise recirculate Q.
            assign mux_out = bus.wren ? bus.D[i] : q_ff;

            // Bit flop: asynchronous reset to the configured value, else capture mux.
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    q_ff <= RESET_VALUE[i];
                else
                    q_ff <= mux_out;
            end
`endif

            assign q_vec[i] = q_ff;
        end
    endgenerate

    assign bus.Q = q_vec;

endmodule

// File: tb/tb_reg_x.sv
// tb_reg_x: directed self-checking bench for reg_x (WIDTH=64, reset value 0)
// driven with a 600 ps clock. Inputs change on the falling edge; Q is
// sampled 100 ps after each rising edge, which also covers the settling
// bound of the gate-delay build.
`timescale 1ps/1ps

module tb_reg_x;

    localparam int W = 64;
    localparam logic [W-1:0] ZERO  = 64'h0;
    localparam logic [W-1:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] BIT32 = 64'h0000_0001_0000_0000;
    localparam logic [W-1:0] SMALL = 64'h0000_0000_0000_1234;

    logic clk;
    logic reset;

    int tests;
    int fails;

    reg_x_if #(.WIDTH(W)) bus ();

    reg_x #(
        .WIDTH       (W),
        .RESET_VALUE (ZERO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #300 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] observed,
                         input logic [W-1:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to the next rising edge and wait for Q to settle.
    task automatic tick();
        @(posedge clk);
        #100;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        bus.wren = 1'b0;
        bus.D    = ZERO;

        // Reset is visible before the first clock edge (first edge at 300 ps).
        #10;
        check("reset_immediate", bus.Q, ZERO);

        // Release reset with wren low: Q stays 0 over 4 edges.
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_reset_hold", bus.Q, ZERO);
        end

        // Hold: data present but wren low for 5 edges.
        @(negedge clk);
        bus.D = BIT32;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_wren0", bus.Q, ZERO);
        end

        // Write 2**32.
        @(negedge clk);
        bus.wren = 1'b1;
        #50;
        check("no_transparency_wren", bus.Q, ZERO);
        tick();
        check("write_bit32", bus.Q, BIT32);

        // Change D mid-cycle: Q unchanged until the next edge.
        @(negedge clk);
        bus.D = ONES;
        #50;
        check("mid_cycle_d_change", bus.Q, BIT32);
        tick();
        check("write_ones", bus.Q, ONES);

        // Asynchronous reset between edges with wren high.
        @(negedge clk);
        reset = 1'b1;
        #10;
        check("async_reset_immediate", bus.Q, ZERO);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("reset_dominates_write", bus.Q, ZERO);
        end

        // Deassert reset: next edge loads D.
        @(negedge clk);
        reset = 1'b0;
        #50;
        check("after_release_before_edge", bus.Q, ZERO);
        tick();
        check("load_after_release", bus.Q, ONES);

        // Write-then-hold.
        @(negedge clk);
        bus.D = BIT32;
        tick();
        check("reload_bit32", bus.Q, BIT32);
        @(negedge clk);
        bus.wren = 1'b0;
        bus.D    = SMALL;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("write_then_hold", bus.Q, BIT32);
        end

        // Zero-register hookup: wren=1, D=0 for 10 edges.
        @(negedge clk);
        bus.wren = 1'b1;
        bus.D    = ZERO;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("zero_register", bus.Q, ZERO);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
